// File: rtl/round_sat_pipe_pkg.sv
// Shared constants and helpers for the round/saturate datapath stages.
// Holds the rounding-mode encodings and the output clamp limits.
package round_sat_pkg;

  localparam logic [1:0] RND_TRUNC   = 2'd0;
  localparam logic [1:0] RND_HALF_UP = 2'd1;
  localparam logic [1:0] RND_CONV    = 2'd2;
  localparam logic [1:0] RND_AWAY    = 2'd3;

  typedef struct packed {
    logic signed [31:0] maxp;
    logic signed [31:0] minn;
  } sat_lim_t;

  // Symmetric clamping gives up the most negative code so that |min| == max.
  function automatic sat_lim_t sat_limits(input int out_w, input bit sym);
    sat_lim_t lim;
    lim.maxp = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lim.minn = sym ? -lim.maxp : -lim.maxp - 32'sd1;
    return lim;
  endfunction

endpackage

// File: rtl/round_sat_pipe_if.sv
// Upstream (t_0) and downstream (i_0) req/ack channels of the round/saturate stage.
// master = the surrounding datapath, slave = the stage itself.
interface round_sat_pipe_if #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) ();

  logic [IN_W-1:0]  t_0_dat;
  logic             t_0_req;
  logic             t_0_ack;
  logic [1:0]       t_0_mode;

  logic [OUT_W-1:0] i_0_dat;
  logic             i_0_sat;
  logic             i_0_req;
  logic             i_0_ack;

  modport master (
    output t_0_dat, t_0_req, t_0_mode, i_0_ack,
    input  t_0_ack, i_0_dat, i_0_sat, i_0_req
  );

  modport slave (
    input  t_0_dat, t_0_req, t_0_mode, i_0_ack,
    output t_0_ack, i_0_dat, i_0_sat, i_0_req
  );

endinterface

// File: rtl/round_sat_pipe_rnd.sv
// Combinational rounding of a signed sample by SHIFT LSBs under a selectable mode.
// The result carries one extra bit so a round-up of the largest value never wraps.
module round_sat_rnd
  import round_sat_pkg::*;
#(
  parameter int IN_W  = 20,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0]    dat,
  input  logic        [1:0]         mode,
  output logic signed [IN_W-SHIFT:0] r
);

  localparam int QW = IN_W - SHIFT;

  logic signed [QW-1:0] q;
  logic                 half;
  logic                 sticky;
  logic                 sign;
  logic                 inc;

  assign q      = dat[IN_W-1:SHIFT];
  assign half   = dat[SHIFT-1];
  assign sticky = |dat[SHIFT-2:0];
  assign sign   = dat[IN_W-1];

  always_comb begin
    inc = 1'b0;
    case (mode)
      RND_TRUNC:   inc = 1'b0;
      RND_HALF_UP: inc = half;
      RND_CONV:    inc = half & (sticky | q[0]);
      default:     inc = half & (sticky | ~sign);
    endcase
  end

  assign r = {q[QW-1], q} + {{QW{1'b0}}, inc};

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage elastic round (S1) and saturate (S2) pipeline with a sticky
// saturation event counter counted at the output handshake.
module round_sat_pipe
  import round_sat_pkg::*;
#(
  parameter int IN_W    = 20,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 4,
  parameter int SYM_SAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  round_sat_pipe_if.slave  bus,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  localparam int RW = IN_W - SHIFT + 1;

  if (SHIFT < 2 || SHIFT > IN_W - OUT_W || OUT_W > IN_W - SHIFT) begin : g_cfg_bad
    $fatal(1, "round_sat_pipe: SHIFT/OUT_W not legal for IN_W");
  end

  localparam sat_lim_t              LIM  = sat_limits(OUT_W, SYM_SAT != 0);
  localparam logic signed [RW-1:0]  MAXP = RW'(LIM.maxp);
  localparam logic signed [RW-1:0]  MINN = RW'(LIM.minn);

  logic signed [RW-1:0] rnd_r;
  logic signed [RW-1:0] s1_r;
  logic                 s1_v;
  logic                 s1_adv;

  logic [OUT_W-1:0]     s2_dat;
  logic                 s2_sat;
  logic                 s2_v;
  logic                 s2_adv;

  logic [OUT_W-1:0]     dat_nxt;
  logic                 sat_nxt;
  logic                 out_xfer;
  logic                 cnt_inc;

  round_sat_rnd #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_rnd (
    .dat  (bus.t_0_dat),
    .mode (bus.t_0_mode),
    .r    (rnd_r)
  );

  assign s2_adv      = !s2_v || bus.i_0_ack;
  assign s1_adv      = !s1_v || s2_adv;
  assign bus.t_0_ack = s1_adv;

  // S1 captures the already-rounded value, so the mode travels with its beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v <= 1'b0;
      s1_r <= '0;
    end else if (s1_adv) begin
      s1_v <= bus.t_0_req;
      if (bus.t_0_req) begin
        s1_r <= rnd_r;
      end
    end
  end

  always_comb begin
    dat_nxt = s1_r[OUT_W-1:0];
    sat_nxt = 1'b0;
    if (s1_r > MAXP) begin
      dat_nxt = MAXP[OUT_W-1:0];
      sat_nxt = 1'b1;
    end else if (s1_r < MINN) begin
      dat_nxt = MINN[OUT_W-1:0];
      sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_v   <= 1'b0;
      s2_dat <= '0;
      s2_sat <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_dat <= dat_nxt;
        s2_sat <= sat_nxt;
      end
    end
  end

  assign bus.i_0_req = s2_v;
  assign bus.i_0_dat = s2_dat;
  assign bus.i_0_sat = s2_sat;

  // Counting on the output handshake makes a stalled beat count exactly once.
  assign out_xfer = s2_v && bus.i_0_ack;
  assign cnt_inc  = out_xfer && s2_sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= {{(CNT_W-1){1'b0}}, cnt_inc};
    end else if (cnt_inc && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed bench for round_sat_pipe: rounding modes, clamping, counter, streaming, reset.
// dut_a: asymmetric clamp, 16-bit counter; dut_b: symmetric clamp, 3-bit counter.
`timescale 1ns/1ps
module tb_round_sat_pipe;
  import round_sat_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  round_sat_pipe_if #(.IN_W(20), .OUT_W(16)) bus_a ();
  round_sat_pipe_if #(.IN_W(20), .OUT_W(16)) bus_b ();

  logic        sat_clr;
  logic [15:0] sat_cnt_a;
  logic [2:0]  sat_cnt_b;
  logic [19:0] in_dat;
  logic        in_req;
  logic [1:0]  in_mode;
  logic        ack_a, ack_b;

  assign bus_a.t_0_dat  = in_dat;
  assign bus_a.t_0_req  = in_req;
  assign bus_a.t_0_mode = in_mode;
  assign bus_a.i_0_ack  = ack_a;
  assign bus_b.t_0_dat  = in_dat;
  assign bus_b.t_0_req  = in_req;
  assign bus_b.t_0_mode = in_mode;
  assign bus_b.i_0_ack  = ack_b;

  round_sat_pipe #(.IN_W(20), .OUT_W(16), .SHIFT(4), .SYM_SAT(0), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .sat_cnt(sat_cnt_a), .sat_clr(sat_clr));

  round_sat_pipe #(.IN_W(20), .OUT_W(16), .SHIFT(4), .SYM_SAT(1), .CNT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .sat_cnt(sat_cnt_b), .sat_clr(sat_clr));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference written as integer arithmetic on the fraction, not as inc bits.
  function automatic logic [16:0] model(input logic [19:0] d, input logic [1:0] m, input bit sym);
    int v, q, fr, r, mn;
    logic s;
    v  = {{12{d[19]}}, d};
    q  = v >>> 4;
    fr = v & 15;
    r  = q;
    case (m)
      2'd1: if (fr >= 8) r = q + 1;
      2'd2: if (fr > 8 || (fr == 8 && (q & 1) != 0)) r = q + 1;
      2'd3: if (fr > 8 || (fr == 8 && v >= 0)) r = q + 1;
      default: r = q;
    endcase
    mn = sym ? -32767 : -32768;
    s  = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
    return {s, 16'(r)};
  endfunction

  typedef struct packed {
    logic [19:0] d;
    logic [1:0]  m;
    logic [15:0] e;
  } vec_t;

  vec_t vecs [16] = '{
    '{20'h00018, RND_TRUNC,   16'h0001}, '{20'h00018, RND_HALF_UP, 16'h0002},
    '{20'h00018, RND_CONV,    16'h0002}, '{20'h00018, RND_AWAY,    16'h0002},
    '{20'h00028, RND_TRUNC,   16'h0002}, '{20'h00028, RND_HALF_UP, 16'h0003},
    '{20'h00028, RND_CONV,    16'h0002}, '{20'h00028, RND_AWAY,    16'h0003},
    '{20'hFFFE8, RND_TRUNC,   16'hFFFE}, '{20'hFFFE8, RND_HALF_UP, 16'hFFFF},
    '{20'hFFFE8, RND_CONV,    16'hFFFE}, '{20'hFFFE8, RND_AWAY,    16'hFFFE},
    '{20'hFFFEC, RND_CONV,    16'hFFFF}, '{20'hFFFEC, RND_AWAY,    16'hFFFF},
    '{20'hFFFF8, RND_CONV,    16'h0000}, '{20'hFFFF8, RND_AWAY,    16'hFFFF}
  };

  typedef struct packed {
    logic [19:0] d;
    logic [1:0]  m;
    logic [15:0] ea;
    logic        sa;
    logic [15:0] eb;
    logic        sb;
  } svec_t;

  svec_t svecs [3] = '{
    '{20'h7FFFF, RND_HALF_UP, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1},
    '{20'h80000, RND_TRUNC,   16'h8000, 1'b0, 16'h8001, 1'b1},
    '{20'h7FFF0, RND_TRUNC,   16'h7FFF, 1'b0, 16'h7FFF, 1'b0}
  };

  logic [15:0] od_a, od_b;
  logic        os_a, os_b;
  int          lat;

  // One beat through both DUTs with output ack held high; returns data and latency.
  task automatic xfer(input logic [19:0] d, input logic [1:0] m, input logic clr_at_out);
    @(posedge clk); #1;
    in_dat = d; in_mode = m; in_req = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_a.t_0_ack && bus_b.t_0_ack) break;
    end
    check("xfer_accept", {31'd0, bus_a.t_0_ack & bus_b.t_0_ack}, 32'd1);
    @(posedge clk); #1;
    in_req = 1'b0;
    lat = 0;
    while (!bus_a.i_0_req && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("xfer_out_req_b", {31'd0, bus_b.i_0_req}, 32'd1);
    od_a = bus_a.i_0_dat; os_a = bus_a.i_0_sat;
    od_b = bus_b.i_0_dat; os_b = bus_b.i_0_sat;
    sat_clr = clr_at_out;
    @(posedge clk); #1;
    sat_clr = 1'b0;
  endtask

  logic [16:0] exp_q [$];
  logic [16:0] e;
  logic [19:0] sd;
  logic [1:0]  sm;
  int          n_got, nsat;
  bit          stream_done;
  bit          prev_stall;
  logic [15:0] prev_dat;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_req = 1'b0; in_dat = '0; in_mode = '0;
    ack_a = 1'b1; ack_b = 1'b1; sat_clr = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req",   {31'd0, bus_a.i_0_req}, 32'd0);
    check("rst_dat",   {16'd0, bus_a.i_0_dat}, 32'd0);
    check("rst_sat",   {31'd0, bus_a.i_0_sat}, 32'd0);
    check("rst_cnt_a", {16'd0, sat_cnt_a}, 32'd0);
    check("rst_cnt_b", {29'd0, sat_cnt_b}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_t_ack", {31'd0, bus_a.t_0_ack}, 32'd1);

    foreach (vecs[i]) begin
      xfer(vecs[i].d, vecs[i].m, 1'b0);
      check($sformatf("rnd_a_%0d", i), {16'd0, od_a}, {16'd0, vecs[i].e});
      check($sformatf("rnd_sat_%0d", i), {31'd0, os_a}, 32'd0);
      check($sformatf("rnd_b_%0d", i), {16'd0, od_b}, {16'd0, vecs[i].e});
      check($sformatf("latency_%0d", i), lat, 32'd2);
    end

    foreach (svecs[i]) begin
      xfer(svecs[i].d, svecs[i].m, 1'b0);
      check($sformatf("sat_dat_a_%0d", i), {16'd0, od_a}, {16'd0, svecs[i].ea});
      check($sformatf("sat_flag_a_%0d", i), {31'd0, os_a}, {31'd0, svecs[i].sa});
      check($sformatf("sat_dat_b_%0d", i), {16'd0, od_b}, {16'd0, svecs[i].eb});
      check($sformatf("sat_flag_b_%0d", i), {31'd0, os_b}, {31'd0, svecs[i].sb});
    end
    check("cnt_after_sat_a", {16'd0, sat_cnt_a}, 32'd1);
    check("cnt_after_sat_b", {29'd0, sat_cnt_b}, 32'd2);

    // saturated beat held at the output for 5 cycles
    @(posedge clk); #1;
    ack_a = 1'b0; ack_b = 1'b0;
    in_dat = 20'h7FFFF; in_mode = RND_HALF_UP; in_req = 1'b1;
    @(negedge clk);
    check("stall_accept", {31'd0, bus_a.t_0_ack}, 32'd1);
    @(posedge clk); #1;
    in_req = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_a.i_0_req) break;
    end
    check("stall_req", {31'd0, bus_a.i_0_req}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_hold_req", {31'd0, bus_a.i_0_req}, 32'd1);
      check("stall_hold_dat", {16'd0, bus_a.i_0_dat}, 32'h7FFF);
      check("stall_cnt", {16'd0, sat_cnt_a}, 32'd1);
    end
    ack_a = 1'b1; ack_b = 1'b1;
    @(posedge clk); #1;
    check("stall_once_a", {16'd0, sat_cnt_a}, 32'd2);
    check("stall_once_b", {29'd0, sat_cnt_b}, 32'd3);
    @(negedge clk);
    check("stall_no_dup", {31'd0, bus_a.i_0_req}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_cnt_after", {16'd0, sat_cnt_a}, 32'd2);

    for (int i = 0; i < 6; i++) begin
      xfer(20'h7FFFF, RND_HALF_UP, 1'b0);
      if (i == 3) check("cnt_b_reach_max", {29'd0, sat_cnt_b}, 32'd7);
    end
    check("cnt_b_sticky", {29'd0, sat_cnt_b}, 32'd7);
    check("cnt_a_8", {16'd0, sat_cnt_a}, 32'd8);

    xfer(20'h7FFFF, RND_HALF_UP, 1'b1);
    check("clr_inc_a", {16'd0, sat_cnt_a}, 32'd1);
    check("clr_inc_b", {29'd0, sat_cnt_b}, 32'd1);
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("clr_only_a", {16'd0, sat_cnt_a}, 32'd0);
    check("clr_only_b", {29'd0, sat_cnt_b}, 32'd0);

    // random stream with random output backpressure on dut_a
    n_got = 0; nsat = 0; stream_done = 1'b0; prev_stall = 1'b0; prev_dat = '0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk); #1;
          case ($urandom_range(0, 3))
            0:       sd = 20'h7FFC0 | 20'($urandom_range(0, 63));
            1:       sd = 20'h80000 | 20'($urandom_range(0, 63));
            default: sd = 20'($urandom);
          endcase
          sm = 2'($urandom_range(0, 3));
          in_dat = sd; in_mode = sm; in_req = 1'b1;
          for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus_a.t_0_ack) break;
          end
          check("stream_accept", {31'd0, bus_a.t_0_ack}, 32'd1);
          exp_q.push_back(model(sd, sm, 1'b0));
        end
        @(posedge clk); #1;
        in_req = 1'b0;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          ack_a = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int cyc = 0; cyc < 3000 && n_got < 100; cyc++) begin
          @(negedge clk);
          if (prev_stall) begin
            check("stable_req", {31'd0, bus_a.i_0_req}, 32'd1);
            check("stable_dat", {16'd0, bus_a.i_0_dat}, {16'd0, prev_dat});
          end
          if (bus_a.i_0_req && ack_a) begin
            if (exp_q.size() == 0) begin
              check("stream_extra", exp_q.size(), 32'd1);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("stream_dat_%0d", n_got), {16'd0, bus_a.i_0_dat}, {16'd0, e[15:0]});
              check($sformatf("stream_sat_%0d", n_got), {31'd0, bus_a.i_0_sat}, {31'd0, e[16]});
              if (e[16]) nsat++;
            end
            n_got++;
          end
          prev_stall = bus_a.i_0_req && !ack_a;
          prev_dat   = bus_a.i_0_dat;
        end
        check("stream_count", n_got, 32'd100);
        stream_done = 1'b1;
      end
    join
    ack_a = 1'b1;
    @(posedge clk); #1;
    check("stream_sat_cnt", {16'd0, sat_cnt_a}, nsat);
    check("stream_drained", exp_q.size(), 32'd0);

    // reset with two beats in flight
    xfer(20'h7FFFF, RND_HALF_UP, 1'b0);
    @(posedge clk); #1;
    ack_a = 1'b0; ack_b = 1'b0;
    in_dat = 20'h7FFFF; in_mode = RND_HALF_UP; in_req = 1'b1;
    @(negedge clk);
    check("inflight_acc1", {31'd0, bus_a.t_0_ack}, 32'd1);
    @(posedge clk); #1;
    in_dat = 20'h00018;
    @(negedge clk);
    check("inflight_acc2", {31'd0, bus_a.t_0_ack}, 32'd1);
    @(posedge clk); #1;
    in_req = 1'b0;
    check("inflight_req", {31'd0, bus_a.i_0_req}, 32'd1);
    check("inflight_sat", {31'd0, bus_a.i_0_sat}, 32'd1);
    check("inflight_t_ack", {31'd0, bus_a.t_0_ack}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req",   {31'd0, bus_a.i_0_req}, 32'd0);
    check("arst_dat",   {16'd0, bus_a.i_0_dat}, 32'd0);
    check("arst_sat",   {31'd0, bus_a.i_0_sat}, 32'd0);
    check("arst_cnt_a", {16'd0, sat_cnt_a}, 32'd0);
    check("arst_req_b", {31'd0, bus_b.i_0_req}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_a = 1'b1; ack_b = 1'b1;
    @(negedge clk);
    check("post_rst_t_ack", {31'd0, bus_a.t_0_ack}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_beat", {31'd0, bus_a.i_0_req}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
